// File: rtl/cross_bar_pkg.sv
// Shared sizes, index types and arbiter state for the crossbar.
// Imported by the arbiter top and its per-slave round-robin units.
package cross_bar_pkg;

  localparam int MASTER_N = 4;
  localparam int SLAVE_N  = 4;
  localparam int ADDR_W   = 32;
  localparam int MASTER_W = $clog2(MASTER_N);
  localparam int SLAVE_W  = $clog2(SLAVE_N);

  localparam int ARB_RESET_PTR = 0;

  typedef logic [MASTER_W-1:0] master_num_t;
  typedef logic [SLAVE_W-1:0]  slave_num_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_t;

endpackage

// File: rtl/cross_bar_rr_arb.sv
// One slave's round-robin arbiter: IDLE/BUSY FSM, priority pointer and
// first-requester-from-pointer pick. Grant is held until ack or drop.
module cross_bar_rr_arb
  import cross_bar_pkg::*;
(
  input  logic                clk,
  input  logic                areset,
  input  logic [MASTER_N-1:0] i_req,
  input  logic                i_ack,
  output master_num_t         o_master_num,
  output logic                o_grant_vld
);

  arb_state_t  r_state;
  master_num_t r_ptr;
  master_num_t r_master_num;
  logic        r_grant_vld;

  master_num_t w_pick;
  logic        w_found;
  master_num_t w_ptr_nxt;
  int          w_idx;

  // Scan upward from the pointer, wrapping at the last master.
  always_comb begin
    w_pick  = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int i = 0; i < MASTER_N; i++) begin
      w_idx = int'(r_ptr) + i;
      if (w_idx >= MASTER_N)
        w_idx = w_idx - MASTER_N;
      if (!w_found && i_req[w_idx]) begin
        w_found = 1'b1;
        w_pick  = master_num_t'(w_idx);
      end
    end
  end

  assign w_ptr_nxt =
    (r_master_num == master_num_t'(MASTER_N - 1)) ?
    '0 : r_master_num + 1'b1;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_state      <= ARB_IDLE;
      r_ptr        <= master_num_t'(ARB_RESET_PTR);
      r_master_num <= '0;
      r_grant_vld  <= 1'b0;
    end else begin
      unique case (r_state)
        ARB_IDLE: begin
          if (w_found) begin
            r_master_num <= w_pick;
            r_grant_vld  <= 1'b1;
            r_state      <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          // Ack wins over a simultaneous drop so the pointer still rotates.
          if (i_ack) begin
            r_grant_vld <= 1'b0;
            r_ptr       <= w_ptr_nxt;
            r_state     <= ARB_IDLE;
          end else if (!i_req[r_master_num]) begin
            r_grant_vld <= 1'b0;
            r_state     <= ARB_IDLE;
          end
        end
        default: begin
          r_grant_vld <= 1'b0;
          r_state     <= ARB_IDLE;
        end
      endcase
    end
  end

  assign o_master_num = r_master_num;
  assign o_grant_vld  = r_grant_vld;

endmodule

// File: rtl/cross_bar_arbiter.sv
// Crossbar arbiter: address decode, one round-robin unit per slave and
// the reverse slave-per-master routing used for the response path.
module cross_bar_arbiter
  import cross_bar_pkg::*;
(
  input  logic                             clk,
  input  logic                             areset,
  input  logic [MASTER_N-1:0]              master_req,
  input  logic [MASTER_N-1:0][ADDR_W-1:0]  master_addr,
  input  logic [SLAVE_N-1:0]               slave_ack,
  output master_num_t [SLAVE_N-1:0]        master_num,
  output logic [SLAVE_N-1:0]               grant_vld,
  output slave_num_t [MASTER_N-1:0]        slave_num,
  output logic [MASTER_N-1:0]              route_vld
);

  slave_num_t [MASTER_N-1:0]           w_tgt;
  logic [SLAVE_N-1:0][MASTER_N-1:0]    w_req_s;

  always_comb begin
    for (int m = 0; m < MASTER_N; m++)
      w_tgt[m] = master_addr[m][ADDR_W-1 -: SLAVE_W];
  end

  always_comb begin
    for (int s = 0; s < SLAVE_N; s++)
      for (int m = 0; m < MASTER_N; m++)
        w_req_s[s][m] = master_req[m] &&
                        (w_tgt[m] == slave_num_t'(s));
  end

  for (genvar s = 0; s < SLAVE_N; s++) begin : g_arb
    cross_bar_rr_arb u_arb (
      .clk          (clk),
      .areset       (areset),
      .i_req        (w_req_s[s]),
      .i_ack        (slave_ack[s]),
      .o_master_num (master_num[s]),
      .o_grant_vld  (grant_vld[s])
    );
  end

  // A master targets one slave, so at most one grant can point at it.
  always_comb begin
    route_vld = '0;
    slave_num = '0;
    for (int s = 0; s < SLAVE_N; s++) begin
      if (grant_vld[s]) begin
        route_vld[master_num[s]] = 1'b1;
        slave_num[master_num[s]] = slave_num_t'(s);
      end
    end
  end

endmodule

// File: tb/tb_cross_bar_arbiter.sv
// Directed plus randomized bench for cross_bar_arbiter against an
// owner/pointer reference model of the per-slave round robin.
module tb_cross_bar_arbiter;
  import cross_bar_pkg::*;

  logic                            clk = 1'b0;
  logic                            areset;
  logic [MASTER_N-1:0]             master_req;
  logic [MASTER_N-1:0][ADDR_W-1:0] master_addr;
  logic [SLAVE_N-1:0]              slave_ack;
  master_num_t [SLAVE_N-1:0]       master_num;
  logic [SLAVE_N-1:0]              grant_vld;
  slave_num_t [MASTER_N-1:0]       slave_num;
  logic [MASTER_N-1:0]             route_vld;

  int checks = 0;
  int errors = 0;

  int owner [SLAVE_N];
  int last  [SLAVE_N];
  int ptr   [SLAVE_N];

  always #5 clk = ~clk;

  cross_bar_arbiter dut (
    .clk         (clk),
    .areset      (areset),
    .master_req  (master_req),
    .master_addr (master_addr),
    .slave_ack   (slave_ack),
    .master_num  (master_num),
    .grant_vld   (grant_vld),
    .slave_num   (slave_num),
    .route_vld   (route_vld)
  );

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int tgt_of(int m);
    return int'(master_addr[m][ADDR_W-1 -: SLAVE_W]);
  endfunction

  task automatic set_addr(int m, int s);
    master_addr[m] = ADDR_W'($urandom);
    master_addr[m][ADDR_W-1 -: SLAVE_W] = slave_num_t'(s);
  endtask

  task automatic model_reset();
    for (int s = 0; s < SLAVE_N; s++) begin
      owner[s] = -1;
      last[s]  = 0;
      ptr[s]   = 0;
    end
  endtask

  task automatic model_step();
    for (int s = 0; s < SLAVE_N; s++) begin
      if (owner[s] >= 0) begin
        if (slave_ack[s]) begin
          ptr[s]   = (owner[s] + 1) % MASTER_N;
          owner[s] = -1;
        end else if (!(master_req[owner[s]] && tgt_of(owner[s]) == s)) begin
          owner[s] = -1;
        end
      end else begin
        for (int k = 0; k < MASTER_N; k++) begin
          int m;
          m = (ptr[s] + k) % MASTER_N;
          if (owner[s] < 0 && master_req[m] && tgt_of(m) == s) begin
            owner[s] = m;
            last[s]  = m;
          end
        end
      end
    end
  endtask

  task automatic check_model();
    logic [SLAVE_N-1:0]        egv;
    master_num_t [SLAVE_N-1:0] emn;
    logic [MASTER_N-1:0]       erv;
    slave_num_t [MASTER_N-1:0] esn;
    egv = '0;
    emn = '0;
    erv = '0;
    esn = '0;
    for (int s = 0; s < SLAVE_N; s++) begin
      egv[s] = (owner[s] >= 0);
      emn[s] = master_num_t'(last[s]);
      if (owner[s] >= 0) begin
        erv[owner[s]] = 1'b1;
        esn[owner[s]] = slave_num_t'(s);
      end
    end
    chk("grant_vld", 64'(grant_vld), 64'(egv));
    chk("master_num", 64'(master_num), 64'(emn));
    chk("route_vld", 64'(route_vld), 64'(erv));
    chk("slave_num", 64'(slave_num), 64'(esn));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  initial begin
    areset      = 1'b1;
    master_req  = '0;
    master_addr = '0;
    slave_ack   = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model();
    @(negedge clk);
    areset = 1'b0;

    // Single request to slave 1, then ack
    @(negedge clk);
    master_addr[0] = 32'h4000_0000;
    master_req = 4'b0001;
    cyc();
    chk("t1_gv", 64'(grant_vld), 64'b0010);
    chk("t1_mn1", 64'(master_num[1]), 64'd0);
    chk("t1_rv0", 64'(route_vld[0]), 64'd1);
    chk("t1_sn0", 64'(slave_num[0]), 64'd1);
    @(negedge clk);
    slave_ack  = 4'b0010;
    master_req = '0;
    cyc();
    chk("t1_rel", 64'(grant_vld[1]), 64'd0);
    @(negedge clk);
    slave_ack = '0;
    cyc();

    // All masters on slave 2: order 0,1,2,3,0 with a bubble
    @(negedge clk);
    for (int m = 0; m < MASTER_N; m++) master_addr[m] = 32'h8000_0000;
    master_req = '1;
    cyc();
    for (int k = 0; k < 5; k++) begin
      chk("t2_order", 64'(master_num[2]), 64'(k % MASTER_N));
      chk("t2_gv", 64'(grant_vld[2]), 64'd1);
      @(negedge clk);
      slave_ack = 4'b0100;
      cyc();
      chk("t2_bubble", 64'(grant_vld[2]), 64'd0);
      @(negedge clk);
      slave_ack = '0;
      cyc();
    end
    @(negedge clk);
    master_req = '0;
    cyc();
    cyc();

    // Parallel grants on slaves 0 and 3
    @(negedge clk);
    set_addr(0, 0);
    set_addr(3, 3);
    master_req = 4'b1001;
    cyc();
    chk("t3_gv", 64'(grant_vld), 64'b1001);
    chk("t3_mn0", 64'(master_num[0]), 64'd0);
    chk("t3_mn3", 64'(master_num[3]), 64'd3);
    chk("t3_rv", 64'(route_vld), 64'b1001);
    @(negedge clk);
    slave_ack  = 4'b1001;
    master_req = '0;
    cyc();
    @(negedge clk);
    slave_ack = '0;
    cyc();

    // Pointer wrap on slave 0 (ptr=1): M3 first, then M0
    @(negedge clk);
    set_addr(0, 0);
    set_addr(3, 0);
    master_req = 4'b1001;
    cyc();
    chk("t4_first", 64'(master_num[0]), 64'd3);
    @(negedge clk);
    slave_ack = 4'b0001;
    cyc();
    @(negedge clk);
    slave_ack = '0;
    cyc();
    chk("t4_wrap", 64'(master_num[0]), 64'd0);
    @(negedge clk);
    slave_ack  = 4'b0001;
    master_req = '0;
    cyc();
    @(negedge clk);
    slave_ack = '0;
    cyc();

    // Drop before ack keeps the pointer (slave 1 ptr=1)
    @(negedge clk);
    set_addr(1, 1);
    set_addr(2, 1);
    master_req = 4'b0110;
    cyc();
    chk("t5_m1", 64'(master_num[1]), 64'd1);
    @(negedge clk);
    master_req = 4'b0100;
    cyc();
    chk("t5_drop", 64'(grant_vld[1]), 64'd0);
    @(negedge clk);
    master_req = 4'b0110;
    cyc();
    chk("t5_again", 64'(master_num[1]), 64'd1);
    @(negedge clk);
    slave_ack  = 4'b0010;
    master_req = '0;
    cyc();
    @(negedge clk);
    slave_ack = '0;
    cyc();

    // Async reset with three live grants
    @(negedge clk);
    set_addr(0, 0);
    set_addr(1, 1);
    set_addr(2, 2);
    master_req = 4'b0111;
    cyc();
    chk("t6_pre", 64'(grant_vld), 64'b0111);
    @(negedge clk);
    #2;
    areset = 1'b1;
    #1;
    chk("t6_gv", 64'(grant_vld), 64'd0);
    chk("t6_rv", 64'(route_vld), 64'd0);
    model_reset();
    @(negedge clk);
    set_addr(1, 3);
    set_addr(2, 3);
    set_addr(3, 3);
    master_req = 4'b1110;
    areset = 1'b0;
    cyc();
    chk("t6_low", 64'(master_num[3]), 64'd1);
    @(negedge clk);
    master_req = '0;
    cyc();

    // Random traffic against the model
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      for (int m = 0; m < MASTER_N; m++) begin
        if ($urandom_range(3) == 0)
          master_req[m] = ~master_req[m];
        if ($urandom_range(7) == 0)
          set_addr(m, int'($urandom_range(SLAVE_N - 1)));
      end
      for (int s = 0; s < SLAVE_N; s++)
        slave_ack[s] = ($urandom_range(2) == 0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
